// File: rtl/seg_scan_driver.sv
// Three-digit multiplexed 7-segment driver: binary 0-255 to BCD by serial double-dabble
// (8 steps, one per clock), with leading-zero blanking and an independent free-running digit scan.
module seg_scan_driver #(
    parameter int CLK_DIV = 50000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [7:0] value,
    input  logic       enable,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       busy,
    output logic       done
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              start;
    logic              finish;

    logic              force_flag;
    logic [7:0]        shown_bin;
    logic [7:0]        cap_bin;
    logic [7:0]        bin_sr;
    logic [11:0]       bcd;
    logic [2:0]        iter;

    logic [11:0]       bcd_adj;
    logic [19:0]       dabble_sh;
    logic [11:0]       bcd_step;
    logic [7:0]        bin_step;

    logic [3:0]        dig_h;
    logic [3:0]        dig_t;
    logic [3:0]        dig_o;

    logic [DIV_W-1:0]  div_cnt;
    logic              tick;
    logic [1:0]        idx;

    logic [3:0]        cur_digit;
    logic              cur_blank;
    logic [6:0]        seg_nxt;
    logic [2:0]        an_nxt;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] c;
        case (d)
            4'd0:    c = 7'b1000000;
            4'd1:    c = 7'b1111001;
            4'd2:    c = 7'b0100100;
            4'd3:    c = 7'b0110000;
            4'd4:    c = 7'b0011001;
            4'd5:    c = 7'b0010010;
            4'd6:    c = 7'b0000010;
            4'd7:    c = 7'b1111000;
            4'd8:    c = 7'b0000000;
            4'd9:    c = 7'b0010000;
            default: c = 7'b1111111;
        endcase
        return c;
    endfunction

    // ---------------- conversion FSM ----------------
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (force_flag || (value != shown_bin)) begin
                    start     = 1'b1;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                if (iter == 3'd7) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == CONV);

    // One double-dabble step: correct each nibble >= 5, then shift {bcd, bin} left.
    always_comb begin
        bcd_adj = bcd;
        for (int n = 0; n < 3; n++) begin
            if (bcd[n*4 +: 4] >= 4'd5) begin
                bcd_adj[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
            end
        end
    end

    assign dabble_sh = {bcd_adj, bin_sr} << 1;
    assign bcd_step  = dabble_sh[19:8];
    assign bin_step  = dabble_sh[7:0];

    always_ff @(posedge clk) begin
        if (clr) begin
            force_flag <= 1'b1;
            shown_bin  <= 8'd0;
            cap_bin    <= 8'd0;
            bin_sr     <= 8'd0;
            bcd        <= 12'd0;
            iter       <= 3'd0;
            dig_h      <= 4'd0;
            dig_t      <= 4'd0;
            dig_o      <= 4'd0;
            done       <= 1'b0;
        end else begin
            done <= finish;
            if (start) begin
                bin_sr  <= value;
                cap_bin <= value;
                bcd     <= 12'd0;
                iter    <= 3'd0;
            end else if (state == CONV) begin
                bin_sr <= bin_step;
                bcd    <= bcd_step;
                iter   <= iter + 3'd1;
            end
            // Digits change only on the final step so a partial result is never shown.
            if (finish) begin
                dig_h      <= bcd_step[11:8];
                dig_t      <= bcd_step[7:4];
                dig_o      <= bcd_step[3:0];
                shown_bin  <= cap_bin;
                force_flag <= 1'b0;
            end
        end
    end

    // ---------------- digit scan ----------------
    assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (clr) begin
            div_cnt <= '0;
            idx     <= 2'd0;
        end else if (tick) begin
            div_cnt <= '0;
            idx     <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_comb begin
        cur_digit = dig_o;
        cur_blank = 1'b0;
        an_nxt    = 3'b111;
        case (idx)
            2'd0: begin
                cur_digit = dig_o;
                an_nxt    = 3'b110;
            end
            2'd1: begin
                cur_digit = dig_t;
                cur_blank = (dig_h == 4'd0) && (dig_t == 4'd0);
                an_nxt    = 3'b101;
            end
            2'd2: begin
                cur_digit = dig_h;
                cur_blank = (dig_h == 4'd0);
                an_nxt    = 3'b011;
            end
            default: begin
                cur_blank = 1'b1;
                an_nxt    = 3'b111;
            end
        endcase
        seg_nxt = cur_blank ? 7'b1111111 : seg_code(cur_digit);
        if (!enable) begin
            seg_nxt = 7'b1111111;
            an_nxt  = 3'b111;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            seg <= 7'b1111111;
            an  <= 3'b111;
        end else begin
            seg <= seg_nxt;
            an  <= an_nxt;
        end
    end

endmodule
